// File: rtl/btl_pkg.sv
// Shared types, defaults and arithmetic helper for the branch target table.
package btl_pkg;

  localparam int D_DEFAULT  = 10;
  localparam int AW_DEFAULT = 4;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } btl_state_e;

  // Wrapping add of a PC and a sign-extended offset. Callers widen both
  // operands to 32 bits and keep the low D bits, so the carry is discarded
  // and the result wraps modulo 2**D in both directions (requires D < 32).
  function automatic logic [31:0] rel_target(input logic [31:0] pc,
                                             input logic [31:0] off);
    return pc + off;
  endfunction

endpackage

// File: rtl/btl_entry_ram.sv
// Entry storage: DEPTH x D value array plus per-entry valid bit.
// One write port (shared by the init sweep and normal programming) and
// one combinational read port, so a same-cycle write is seen only by
// the next read.
module btl_entry_ram
  import btl_pkg::*;
#(
  parameter int D  = D_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [D-1:0]  wdata_i,
  input  logic          wvalid_i,
  input  logic [AW-1:0] raddr_i,
  output logic [D-1:0]  rdata_o,
  output logic          rvalid_o
);

  localparam int DEPTH = 1 << AW;

  logic [D-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  // Write one entry and its valid bit; contents are defined by the init sweep.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
      vld_q[waddr_i] <= wvalid_i;
    end
  end

  assign rdata_o  = mem_q[raddr_i];
  assign rvalid_o = vld_q[raddr_i];

endmodule

// File: rtl/branch_target_lut.sv
// Run-time programmable branch target table: init sweep FSM, write path,
// and registered lookup (absolute, PC-relative, or PC+1 fall-through).
module branch_target_lut
  import btl_pkg::*;
#(
  parameter int D  = D_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lookup_valid,
  input  logic [AW-1:0] lookup_idx,
  input  logic          lookup_rel,
  input  logic [D-1:0]  pc,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [D-1:0]  wr_data,
  output logic          busy,
  output logic [D-1:0]  target,
  output logic          target_valid,
  output logic          miss
);

  localparam int DEPTH = 1 << AW;

  btl_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [D-1:0]  target_q, target_d;
  logic          tv_q, tv_d;
  logic          miss_q, miss_d;

  logic          ram_we_s;
  logic [AW-1:0] ram_waddr_s;
  logic [D-1:0]  ram_wdata_s;
  logic          ram_wvalid_s;
  logic [D-1:0]  ram_rdata_s;
  logic          ram_rvalid_s;

  btl_entry_ram #(.D(D), .AW(AW)) u_ram (
    .clk      (clk),
    .we_i     (ram_we_s),
    .waddr_i  (ram_waddr_s),
    .wdata_i  (ram_wdata_s),
    .wvalid_i (ram_wvalid_s),
    .raddr_i  (lookup_idx),
    .rdata_o  (ram_rdata_s),
    .rvalid_o (ram_rvalid_s)
  );

  // Next state, sweep counter, RAM write steering and lookup result.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    target_d     = target_q;
    miss_d       = miss_q;
    tv_d         = 1'b0;
    ram_we_s     = 1'b0;
    ram_waddr_s  = wr_idx;
    ram_wdata_s  = wr_data;
    ram_wvalid_s = 1'b1;
    case (state_q)
      ST_INIT: begin
        // Sweep owns the write port; external writes and lookups are dropped.
        ram_we_s     = 1'b1;
        ram_waddr_s  = cnt_q;
        ram_wdata_s  = {D{1'b0}};
        ram_wvalid_s = 1'b0;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
          cnt_d   = {AW{1'b0}};
          busy_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + {{(AW-1){1'b0}}, 1'b1};
          busy_d = 1'b1;
        end
      end
      ST_READY: begin
        ram_we_s = wr_en;
        busy_d   = 1'b0;
        if (lookup_valid) begin
          tv_d = 1'b1;
          if (!ram_rvalid_s) begin
            target_d = pc + {{(D-1){1'b0}}, 1'b1};
            miss_d   = 1'b1;
          end else if (lookup_rel) begin
            target_d = D'(rel_target({{(32-D){1'b0}}, pc},
                                     {{(32-D){ram_rdata_s[D-1]}}, ram_rdata_s}));
            miss_d   = 1'b0;
          end else begin
            target_d = ram_rdata_s;
            miss_d   = 1'b0;
          end
        end else begin
          tv_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {AW{1'b0}};
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset restarts the sweep and drops any lookup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= {AW{1'b0}};
      busy_q   <= 1'b1;
      target_q <= {D{1'b0}};
      tv_q     <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      target_q <= target_d;
      tv_q     <= tv_d;
      miss_q   <= miss_d;
    end
  end

  assign busy         = busy_q;
  assign target       = target_q;
  assign target_valid = tv_q;
  assign miss         = miss_q;

endmodule

// File: tb/tb_branch_target_lut.sv
// Self-checking bench for branch_target_lut with a behavioural table model.
module tb_branch_target_lut;

  localparam int D     = 10;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MOD   = 1 << D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lookup_valid;
  logic [AW-1:0] lookup_idx;
  logic          lookup_rel;
  logic [D-1:0]  pc;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [D-1:0]  wr_data;
  logic          busy;
  logic [D-1:0]  target;
  logic          target_valid;
  logic          miss;

  int vectors = 0;
  int errors  = 0;

  int mdata [DEPTH];
  bit mvld  [DEPTH];

  branch_target_lut #(.D(D), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_idx   (lookup_idx),
    .lookup_rel   (lookup_rel),
    .pc           (pc),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .busy         (busy),
    .target       (target),
    .target_valid (target_valid),
    .miss         (miss)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_target(int idx, bit rel, int p);
    int off;
    if (!mvld[idx]) return (p + 1) % MOD;
    if (!rel) return mdata[idx];
    off = (mdata[idx] >= MOD / 2) ? mdata[idx] - MOD : mdata[idx];
    return ((p + off) % MOD + MOD) % MOD;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      mdata[i] = 0;
      mvld[i]  = 1'b0;
    end
  endtask

  // One cycle: optional lookup and optional write, checked against the model.
  task automatic cycle(input bit lv, input int idx, input bit rel, input int p,
                       input bit we, input int widx, input int wd, input string name);
    int et;
    bit em;
    lookup_valid = lv;
    lookup_idx   = idx[AW-1:0];
    lookup_rel   = rel;
    pc           = p[D-1:0];
    wr_en        = we;
    wr_idx       = widx[AW-1:0];
    wr_data      = wd[D-1:0];
    et = exp_target(idx, rel, p);
    em = !mvld[idx];
    step();
    if (we) begin
      mdata[widx] = wd % MOD;
      mvld[widx]  = 1'b1;
    end
    lookup_valid = 1'b0;
    wr_en        = 1'b0;
    vectors++;
    if (target_valid !== lv) begin
      errors++;
      $display("FAIL %s target_valid: got %b want %b", name, target_valid, lv);
    end
    if (lv) begin
      vectors++;
      if (target !== et[D-1:0]) begin
        errors++;
        $display("FAIL %s target: got %0d want %0d", name, target, et);
      end
      vectors++;
      if (miss !== em) begin
        errors++;
        $display("FAIL %s miss: got %b want %b", name, miss, em);
      end
    end
  endtask

  // After reset release: hammer lookups and writes during the sweep, then
  // require exactly DEPTH busy cycles with no target_valid.
  task automatic wait_init(input string name);
    int cnt = 0;
    clear_model();
    while (busy === 1'b1 && cnt < 100) begin
      lookup_valid = 1'b1;
      lookup_idx   = AW'($urandom_range(DEPTH - 1, 0));
      lookup_rel   = 1'($urandom_range(1, 0));
      pc           = D'($urandom_range(MOD - 1, 0));
      wr_en        = 1'b1;
      wr_idx       = 4'd4;
      wr_data      = 10'd76;
      cnt++;
      step();
      vectors++;
      if (target_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s tv_during_init: got %b want 0 (cycle %0d)", name, target_valid, cnt);
      end
    end
    lookup_valid = 1'b0;
    wr_en        = 1'b0;
    vectors++;
    if (cnt != DEPTH) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, cnt, DEPTH);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (busy !== 1'b1 || target !== 10'd0 || target_valid !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_outputs: got busy=%b target=%0d tv=%b miss=%b want 1,0,0,0",
               name, busy, target, target_valid, miss);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_outputs("reset");
    end
    rst_n = 1'b1;
    wait_init("reset");
    // First cycle with busy low: lookup must be accepted.
    cycle(1'b1, 3, 1'b0, 20, 1'b0, 0, 0, "first_lookup");
  endtask

  task automatic test_busy_gating();
    // The sweep saw wr_en idx 4 = 76 every cycle; it must have been dropped.
    cycle(1'b1, 4, 1'b0, 300, 1'b0, 0, 0, "gating_idx4");
    cycle(1'b1, 4, 1'b1, 1023, 1'b0, 0, 0, "gating_idx4_rel");
  endtask

  task automatic test_absolute();
    cycle(1'b0, 0, 1'b0, 0, 1'b1, 2, 45, "abs_write");
    cycle(1'b1, 2, 1'b0, 7, 1'b0, 0, 0, "abs_lookup");
    cycle(1'b1, 2, 1'b0, 1023, 1'b0, 0, 0, "abs_pc_ignored");
    cycle(1'b0, 2, 1'b0, 0, 1'b0, 0, 0, "idle_tv_low");
  endtask

  task automatic test_relative_wrap();
    cycle(1'b0, 0, 1'b0, 0, 1'b1, 9, 10'h3FB, "rel_write9");
    cycle(1'b1, 9, 1'b1, 4, 1'b0, 0, 0, "rel_neg_wrap");
    cycle(1'b0, 0, 1'b0, 0, 1'b1, 8, 20, "rel_write8");
    cycle(1'b1, 8, 1'b1, 1023, 1'b0, 0, 0, "rel_pos_wrap");
    cycle(1'b1, 7, 1'b1, 1023, 1'b0, 0, 0, "miss_wrap");
    cycle(1'b1, 9, 1'b0, 4, 1'b0, 0, 0, "rel9_as_abs");
  endtask

  task automatic test_collision();
    cycle(1'b0, 0, 1'b0, 0, 1'b1, 5, 83, "coll_prog");
    cycle(1'b1, 5, 1'b0, 0, 1'b1, 5, 91, "coll_same_cycle");
    cycle(1'b1, 5, 1'b0, 0, 1'b0, 0, 0, "coll_next");
    // First write to an unprogrammed index in the same cycle as its lookup.
    cycle(1'b1, 11, 1'b0, 50, 1'b1, 11, 600, "coll_unprog");
    cycle(1'b1, 11, 1'b0, 50, 1'b1, 12, 33, "coll_diff_idx");
    cycle(1'b1, 12, 1'b0, 50, 1'b0, 0, 0, "coll_diff_after");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(3, 0) != 0), int'($urandom_range(DEPTH - 1, 0)),
            1'($urandom_range(1, 0)), int'($urandom_range(MOD - 1, 0)),
            1'($urandom_range(2, 0) == 0), int'($urandom_range(DEPTH - 1, 0)),
            int'($urandom_range(MOD - 1, 0)), "random");
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 0, 1'b0, 0, 1'b1, 1, 10, "midrst_prog");
    cycle(1'b1, 1, 1'b0, 0, 1'b0, 0, 0, "midrst_prog_check");
    lookup_valid = 1'b1;
    lookup_idx   = 4'd1;
    lookup_rel   = 1'b0;
    pc           = 10'd100;
    rst_n        = 1'b0;
    step();
    lookup_valid = 1'b0;
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    wait_init("midrst");
    cycle(1'b1, 1, 1'b0, 100, 1'b0, 0, 0, "midrst_cleared");
  endtask

  initial begin
    rst_n        = 1'b0;
    lookup_valid = 1'b0;
    lookup_idx   = 4'd0;
    lookup_rel   = 1'b0;
    pc           = 10'd0;
    wr_en        = 1'b0;
    wr_idx       = 4'd0;
    wr_data      = 10'd0;
    clear_model();
    test_reset();
    test_busy_gating();
    test_absolute();
    test_relative_wrap();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    test_busy_gating();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
